esm_instr_buffer: RTL and testbench

- Upstream instruction window for the ESM core.
- Accepts fetched instructions over a valid/ready handshake and stores each one in a free slot of a bs-entry buffer.
- For each accepted instruction, presents the instruction, its slot index and the slot valid bitmap to the ESM core for dependency analysis.
- Consumes the core's selected slot (next_buffer_index plus issue strobe) to read out and retire that entry.

---
 rtl/esm_instr_buffer.sv | 139 +++++++++++++
 tb/tb_esm_instr_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_instr_buffer.sv
// Instruction window in front of the ESM core: allocates fetched words into the
// lowest free slot, reports each allocation, and retires the slot the core selects.
module esm_instr_buffer #(
  parameter int Instruction_word_size = 32,
  parameter int bs                    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_valid,
  input  logic [Instruction_word_size-1:0] fetch_instr,
  output logic                             fetch_ready,
  input  logic                             flush,
  input  logic                             issue_en,
  input  logic [$clog2(bs)-1:0]            issue_index,
  output logic [Instruction_word_size-1:0] Instr_out,
  output logic [$clog2(bs)-1:0]            buffer_index,
  output logic                             alloc_valid,
  output logic [0:bs-1]                    valid_entries,
  output logic [Instruction_word_size-1:0] issued_instr,
  output logic                             issued_valid,
  output logic [$clog2(bs):0]              occupancy,
  output logic                             issue_err
);

  localparam int IW = $clog2(bs);

  logic [Instruction_word_size-1:0] mem [bs];
  logic [0:bs-1]                    valid_q;
  logic [0:bs-1]                    valid_d;
  logic [IW:0]                      occ_q;
  logic [IW:0]                      occ_d;
  logic [IW-1:0]                    free_idx;
  logic                             accept;
  logic                             slot_hit;
  logic                             issue_ok;
  logic                             issue_bad;

  logic                             alloc_valid_q;
  logic [Instruction_word_size-1:0] instr_out_q;
  logic [IW-1:0]                    buffer_index_q;
  logic                             issued_valid_q;
  logic [Instruction_word_size-1:0] issued_instr_q;
  logic                             issue_err_q;

  // Lowest-index free slot; scanning downward lets the smallest index win.
  always_comb begin
    free_idx = '0;
    for (int i = bs - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = i[IW-1:0];
      end
    end
  end

  assign fetch_ready = ~&valid_q;
  assign accept      = fetch_valid & fetch_ready & ~flush;
  assign slot_hit    = valid_q[issue_index];
  assign issue_ok    = issue_en & slot_hit & ~flush;
  assign issue_bad   = issue_en & ~slot_hit & ~flush;

  // Accept and issue always touch different slots: one is free, the other valid.
  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (accept) begin
        valid_d[free_idx] = 1'b1;
      end
      if (issue_ok) begin
        valid_d[issue_index] = 1'b0;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !issue_ok) begin
      occ_d = occ_q + {{IW{1'b0}}, 1'b1};
    end else if (issue_ok && !accept) begin
      occ_d = occ_q - {{IW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      occ_q       <= '0;
      issue_err_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      if (flush) begin
        issue_err_q <= 1'b0;
      end else if (issue_bad) begin
        issue_err_q <= 1'b1;
      end
    end
  end

  // Slot storage carries no reset; the valid bitmap alone says what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[free_idx] <= fetch_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_valid_q  <= 1'b0;
      instr_out_q    <= '0;
      buffer_index_q <= '0;
      issued_valid_q <= 1'b0;
      issued_instr_q <= '0;
    end else begin
      alloc_valid_q  <= accept;
      issued_valid_q <= issue_ok;
      if (accept) begin
        instr_out_q    <= fetch_instr;
        buffer_index_q <= free_idx;
      end
      if (issue_ok) begin
        issued_instr_q <= mem[issue_index];
      end
    end
  end

  assign valid_entries = valid_q;
  assign occupancy     = occ_q;
  assign issue_err     = issue_err_q;
  assign alloc_valid   = alloc_valid_q;
  assign Instr_out     = instr_out_q;
  assign buffer_index  = buffer_index_q;
  assign issued_valid  = issued_valid_q;
  assign issued_instr  = issued_instr_q;

endmodule

// File: tb/tb_esm_instr_buffer.sv
// Bench for esm_instr_buffer (bs=4): directed scenarios plus random traffic
// checked against a slot-array reference model.
module tb_esm_instr_buffer;

  localparam int W  = 32;
  localparam int BS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fv;
  logic [W-1:0]  fi;
  logic          fetch_ready;
  logic          fl;
  logic          ie;
  logic [1:0]    ii;
  logic [W-1:0]  Instr_out;
  logic [1:0]    buffer_index;
  logic          alloc_valid;
  logic [0:BS-1] valid_entries;
  logic [W-1:0]  issued_instr;
  logic          issued_valid;
  logic [2:0]    occupancy;
  logic          issue_err;

  int checks   = 0;
  int failures = 0;

  bit         mdl_valid [BS];
  logic [W-1:0] mdl_mem [BS];
  bit         mdl_err;
  bit         exp_av;
  bit         exp_iv;
  logic [W-1:0] exp_instr;
  logic [W-1:0] exp_issued;
  logic [1:0] exp_idx;

  esm_instr_buffer #(.Instruction_word_size(W), .bs(BS)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fv), .fetch_instr(fi), .fetch_ready(fetch_ready),
    .flush(fl), .issue_en(ie), .issue_index(ii),
    .Instr_out(Instr_out), .buffer_index(buffer_index), .alloc_valid(alloc_valid),
    .valid_entries(valid_entries), .issued_instr(issued_instr),
    .issued_valid(issued_valid), .occupancy(occupancy), .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  function automatic int mdl_count();
    int n = 0;
    for (int i = 0; i < BS; i++) n += mdl_valid[i];
    return n;
  endfunction

  function automatic logic [0:BS-1] mdl_bitmap();
    logic [0:BS-1] v;
    for (int i = 0; i < BS; i++) v[i] = mdl_valid[i];
    return v;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < BS; i++) mdl_valid[i] = 1'b0;
    mdl_err = 0; exp_av = 0; exp_iv = 0;
    exp_instr = '0; exp_issued = '0; exp_idx = '0;
  endtask

  // Advance one clock; the model decides everything from pre-edge state.
  task automatic step();
    bit acc, iok, ibad;
    int slot;
    logic [W-1:0] idata;
    slot = -1;
    for (int i = 0; i < BS; i++) if (!mdl_valid[i] && slot < 0) slot = i;
    acc   = fv && (slot >= 0) && !fl;
    iok   = ie && mdl_valid[ii] && !fl;
    ibad  = ie && !mdl_valid[ii] && !fl;
    idata = mdl_mem[ii];
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < BS; i++) mdl_valid[i] = 1'b0;
      mdl_err = 0; exp_av = 0; exp_iv = 0;
    end else begin
      exp_av = acc;
      exp_iv = iok;
      if (acc) begin
        mdl_mem[slot] = fi; mdl_valid[slot] = 1'b1;
        exp_instr = fi; exp_idx = slot[1:0];
      end
      if (iok) begin
        exp_issued = idata; mdl_valid[ii] = 1'b0;
      end
      if (ibad) mdl_err = 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    fv = 0; fi = '0; fl = 0; ie = 0; ii = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    mdl_reset();
    #12;
    checks++; if (valid_entries !== 4'b0000 || occupancy !== 3'd0 || issue_err !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_state valid=%b occ=%0d err=%b exp 0000/0/0", valid_entries, occupancy, issue_err);
    end
    checks++; if (alloc_valid !== 1'b0 || issued_valid !== 1'b0 || Instr_out !== '0 || issued_instr !== '0 || buffer_index !== 2'd0) begin
      failures++; $display("[TB] FAIL reset_outputs av=%b iv=%b io=%h ii=%h bi=%0d exp all 0", alloc_valid, issued_valid, Instr_out, issued_instr, buffer_index);
    end
    checks++; if (fetch_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready got=%b exp=1", fetch_ready);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_fill();
    logic [0:BS-1] exp_map [4];
    exp_map[0] = 4'b1000; exp_map[1] = 4'b1100; exp_map[2] = 4'b1110; exp_map[3] = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      fv = 1; fi = 32'hA0 + i;
      step();
      checks++; if (alloc_valid !== 1'b1 || buffer_index !== i[1:0] || Instr_out !== 32'hA0 + i) begin
        failures++; $display("[TB] FAIL fill_alloc[%0d] av=%b idx=%0d instr=%h exp 1/%0d/%h", i, alloc_valid, buffer_index, Instr_out, i, 32'hA0 + i);
      end
      checks++; if (valid_entries !== exp_map[i] || occupancy !== 3'(i + 1)) begin
        failures++; $display("[TB] FAIL fill_map[%0d] valid=%b occ=%0d exp %b/%0d", i, valid_entries, occupancy, exp_map[i], i + 1);
      end
    end
    checks++; if (fetch_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL fill_ready got=%b exp=0", fetch_ready);
    end
  endtask

  task automatic test_full_issue();
    fv = 1; fi = 32'hB0;
    step();
    checks++; if (alloc_valid !== 1'b0 || valid_entries !== 4'b1111) begin
      failures++; $display("[TB] FAIL full_reject av=%b valid=%b exp 0/1111", alloc_valid, valid_entries);
    end
    ie = 1; ii = 2'd2;
    step();
    checks++; if (issued_valid !== 1'b1 || issued_instr !== 32'hA2 || valid_entries !== 4'b1101 || fetch_ready !== 1'b1 || alloc_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL full_issue iv=%b instr=%h valid=%b rdy=%b av=%b exp 1/a2/1101/1/0", issued_valid, issued_instr, valid_entries, fetch_ready, alloc_valid);
    end
    ie = 0;
    step();
    checks++; if (alloc_valid !== 1'b1 || buffer_index !== 2'd2 || Instr_out !== 32'hB0 || issued_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL refill av=%b idx=%0d instr=%h iv=%b exp 1/2/b0/0", alloc_valid, buffer_index, Instr_out, issued_valid);
    end
    fv = 0;
  endtask

  task automatic test_simultaneous();
    idle_inputs(); fl = 1; step(); fl = 0;
    fv = 1; fi = 32'hD0; step();
    fi = 32'hD1; step();
    fi = 32'hC0; ie = 1; ii = 2'd0;
    step();
    checks++; if (alloc_valid !== 1'b1 || buffer_index !== 2'd2 || Instr_out !== 32'hC0) begin
      failures++; $display("[TB] FAIL simul_alloc av=%b idx=%0d instr=%h exp 1/2/c0", alloc_valid, buffer_index, Instr_out);
    end
    checks++; if (valid_entries !== 4'b0110 || occupancy !== 3'd2 || issued_valid !== 1'b1 || issued_instr !== 32'hD0) begin
      failures++; $display("[TB] FAIL simul_issue valid=%b occ=%0d iv=%b instr=%h exp 0110/2/1/d0", valid_entries, occupancy, issued_valid, issued_instr);
    end
    idle_inputs();
  endtask

  task automatic test_invalid_issue();
    ie = 1; ii = 2'd3;
    step();
    checks++; if (issue_err !== 1'b1 || valid_entries !== 4'b0110 || occupancy !== 3'd2 || issued_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL bad_issue err=%b valid=%b occ=%0d iv=%b exp 1/0110/2/0", issue_err, valid_entries, occupancy, issued_valid);
    end
    ie = 0;
    step(); step();
    checks++; if (issue_err !== 1'b1) begin
      failures++; $display("[TB] FAIL err_sticky got=%b exp=1", issue_err);
    end
  endtask

  task automatic test_flush();
    fv = 1; fi = 32'hE0; ie = 1; ii = 2'd1; fl = 1;
    step();
    checks++; if (valid_entries !== 4'b0000 || occupancy !== 3'd0 || issue_err !== 1'b0 || alloc_valid !== 1'b0 || issued_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL flush valid=%b occ=%0d err=%b av=%b iv=%b exp 0000/0/0/0/0", valid_entries, occupancy, issue_err, alloc_valid, issued_valid);
    end
    idle_inputs();
    step();
    checks++; if (alloc_valid !== 1'b0 || issued_valid !== 1'b0 || valid_entries !== 4'b0000) begin
      failures++; $display("[TB] FAIL post_flush av=%b iv=%b valid=%b exp 0/0/0000", alloc_valid, issued_valid, valid_entries);
    end
  endtask

  task automatic test_async_reset();
    fv = 1;
    for (int i = 0; i < 3; i++) begin fi = 32'hF0 + i; step(); end
    #2 rst = 1'b0;
    mdl_reset();
    #1;
    checks++; if (valid_entries !== 4'b0000 || occupancy !== 3'd0 || alloc_valid !== 1'b0 || Instr_out !== '0 || buffer_index !== 2'd0) begin
      failures++; $display("[TB] FAIL async_rst valid=%b occ=%0d av=%b io=%h bi=%0d exp 0000/0/0/0/0", valid_entries, occupancy, alloc_valid, Instr_out, buffer_index);
    end
    idle_inputs();
    @(negedge clk); rst = 1'b1;
    step();
    checks++; if (alloc_valid !== 1'b0 || issued_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_no_pulse av=%b iv=%b exp 0/0", alloc_valid, issued_valid);
    end
    fv = 1; fi = 32'h55;
    step();
    checks++; if (alloc_valid !== 1'b1 || buffer_index !== 2'd0 || Instr_out !== 32'h55 || valid_entries !== 4'b1000) begin
      failures++; $display("[TB] FAIL rst_first_slot av=%b idx=%0d instr=%h valid=%b exp 1/0/55/1000", alloc_valid, buffer_index, Instr_out, valid_entries);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      fv = ($urandom_range(0, 99) < 60);
      fi = $urandom;
      fl = ($urandom_range(0, 31) == 0);
      ie = ($urandom_range(0, 99) < 50);
      ii = 2'($urandom_range(0, BS - 1));
      step();
      checks++; if (valid_entries !== mdl_bitmap() || occupancy !== 3'(mdl_count()) || fetch_ready !== (mdl_count() < BS)) begin
        failures++; $display("[TB] FAIL rnd_state[%0d] valid=%b occ=%0d rdy=%b exp %b/%0d/%b", n, valid_entries, occupancy, fetch_ready, mdl_bitmap(), mdl_count(), mdl_count() < BS);
      end
      checks++; if (alloc_valid !== exp_av || (exp_av && (Instr_out !== exp_instr || buffer_index !== exp_idx))) begin
        failures++; $display("[TB] FAIL rnd_alloc[%0d] av=%b instr=%h idx=%0d exp %b/%h/%0d", n, alloc_valid, Instr_out, buffer_index, exp_av, exp_instr, exp_idx);
      end
      checks++; if (issued_valid !== exp_iv || (exp_iv && issued_instr !== exp_issued) || issue_err !== mdl_err) begin
        failures++; $display("[TB] FAIL rnd_issue[%0d] iv=%b instr=%h err=%b exp %b/%h/%b", n, issued_valid, issued_instr, issue_err, exp_iv, exp_issued, mdl_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_issue();
    test_simultaneous();
    test_invalid_issue();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
